// File: rtl/uart_tx_peripheral_if.sv
// CPU data-memory port as seen by the UART transmitter: store strobe, address
// and data in; decode hit and read data back out to the load path.
interface uart_tx_peripheral_if;
    logic        memory_write_en;
    logic [31:0] memory_address;
    logic [31:0] memory_write_value;
    logic        select;
    logic [31:0] read_value;

    modport master (
        output memory_write_en, memory_address, memory_write_value,
        input  select, read_value
    );

    modport slave (
        input  memory_write_en, memory_address, memory_write_value,
        output select, read_value
    );
endinterface

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to DATA queue bytes in a FIFO,
// STATUS reports full/empty/busy/overflow/count, the FSM drives the tx pin.
module uart_tx_peripheral #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    uart_tx_peripheral_if.slave   bus,
    output logic                  tx
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CLK_W = $clog2(CLKS_PER_BIT);

    localparam logic [31:0]      STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [CLK_W-1:0] LAST_CLK    = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DEPTH       = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e            state_q, state_d;
    logic [CLK_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        fifo_mem [FIFO_DEPTH];

    logic        hit_data, hit_status;
    logic        push_req, push_acc, pop, clear_ovf, bit_done;
    logic [31:0] status;

    always_comb begin
        hit_data   = (bus.memory_address == BASE_ADDR);
        hit_status = (bus.memory_address == STATUS_ADDR);
        push_req   = bus.memory_write_en && hit_data;
        clear_ovf  = bus.memory_write_en && hit_status && bus.memory_write_value[3];

        status        = 32'd0;
        status[0]     = (count_q == DEPTH);
        status[1]     = (count_q == '0);
        status[2]     = (state_q != IDLE) || (count_q != '0);
        status[3]     = overflow_q;
        status[15:8]  = 8'(count_q);

        bus.select     = hit_data || hit_status;
        bus.read_value = hit_status ? status : 32'd0;
    end

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        bit_done  = (clk_cnt_q == LAST_CLK);

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop       = 1'b1;
                    shift_d   = fifo_mem[rd_ptr_q];
                    tx_d      = 1'b0;
                    clk_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_done) begin
                    tx_d      = shift_q[0];
                    clk_cnt_d = '0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_W'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Shift right so the next bit to send is always shift[1] -> shift[0].
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_W'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A full FIFO still accepts a push when the head leaves on the same edge.
        push_acc   = push_req && ((count_q != DEPTH) || pop);
        wr_ptr_d   = push_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop      ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push_acc) - CNT_W'(pop);
        overflow_d = (push_req && !push_acc) ? 1'b1 :
                     clear_ovf               ? 1'b0 : overflow_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: FIFO storage has no reset; count/pointers alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (push_acc) fifo_mem[wr_ptr_q] <= bus.memory_write_value[7:0];
    end

    assign tx = tx_q;
endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Bench for uart_tx_peripheral: scenario tasks drive CPU stores, a serial
// monitor decodes tx frames and pops expected bytes from a scoreboard queue.
module tb_uart_tx_peripheral;
    localparam logic [31:0] BASE        = 32'hFFFF_0000;
    localparam logic [31:0] STATUS_ADDR = BASE + 32'd4;
    localparam int          CPB         = 4;
    localparam int          DEPTH       = 4;
    localparam int          FRAME       = 10 * CPB;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic tx;
    uart_tx_peripheral_if bus ();

    uart_tx_peripheral #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus),
        .tx     (tx)
    );

    always #5 clock = ~clock;

    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    logic [7:0] sb [$];
    logic mon_en = 1'b1;
    logic in_frame = 1'b0;
    int   last_end = -1;
    int   b2b_cnt = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Serial monitor: samples on falling edges, validates the whole 8N1 frame shape.
    initial begin
        forever begin
            @(negedge clock);
            if (mon_en && reset_n && tx === 1'b0) begin
                int         start;
                logic       shape_ok;
                logic [7:0] b;
                logic [7:0] exp_b;
                in_frame = 1'b1;
                start    = cyc;
                shape_ok = 1'b1;
                b        = 8'h00;
                if (start == last_end) b2b_cnt++;
                for (int s = 1; s < FRAME; s++) begin
                    @(negedge clock);
                    if (s < CPB) begin
                        if (tx !== 1'b0) shape_ok = 1'b0;
                    end else if (s < 9 * CPB) begin
                        if ((s - CPB) % CPB == 0) b[(s - CPB) / CPB] = tx;
                        else if (tx !== b[(s - CPB) / CPB]) shape_ok = 1'b0;
                    end else begin
                        if (tx !== 1'b1) shape_ok = 1'b0;
                    end
                end
                last_end = start + FRAME;
                checks++;
                if (!shape_ok) $display("FAIL frame_shape: frame at cycle %0d has bad start/data/stop timing", start);
                else passed++;
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL frame_byte: got %02h, expected no frame", b);
                end else begin
                    exp_b = sb.pop_front();
                    if (b !== exp_b) $display("FAIL frame_byte: got %02h expected %02h", b, exp_b);
                    else passed++;
                end
                in_frame = 1'b0;
            end
        end
    end

    task automatic bus_drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        bus.memory_write_en    = we;
        bus.memory_address     = a;
        bus.memory_write_value = d;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || in_frame) && n < 4000) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        checks++;
        if (n >= 4000) $display("FAIL drain_timeout: %0d bytes still queued after %0d cycles", sb.size(), n);
        else passed++;
    endtask

    task automatic test_reset();
        bus.memory_write_en    = 1'b0;
        bus.memory_address     = STATUS_ADDR;
        bus.memory_write_value = 32'd0;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx);
        else passed++;
        checks++;
        if (bus.read_value !== 32'h2) $display("FAIL reset_status: got %08h expected 00000002", bus.read_value);
        else passed++;
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (tx !== 1'b1 || bus.read_value !== 32'h2)
            $display("FAIL post_reset: tx %b status %08h expected 1 / 00000002", tx, bus.read_value);
        else passed++;
    endtask

    task automatic test_comb_read();
        bus_drive(1'b0, STATUS_ADDR, 32'd0);
        #1;
        checks++;
        if (bus.select !== 1'b1 || bus.read_value !== 32'h2)
            $display("FAIL comb_status: select %b read %08h expected 1 / 00000002", bus.select, bus.read_value);
        else passed++;
        bus.memory_address = BASE;
        #1;
        checks++;
        if (bus.select !== 1'b1 || bus.read_value !== 32'h0)
            $display("FAIL comb_data: select %b read %08h expected 1 / 00000000", bus.select, bus.read_value);
        else passed++;
        bus.memory_address = STATUS_ADDR;
    endtask

    task automatic test_single_frame();
        sb.push_back(8'hA5);
        bus_drive(1'b1, BASE, 32'h0000_00A5);
        bus_drive(1'b0, STATUS_ADDR, 32'd0);
        #1;
        checks++;
        if (tx !== 1'b1 || bus.read_value !== 32'h0000_0104)
            $display("FAIL push_status: tx %b status %08h expected 1 / 00000104", tx, bus.read_value);
        else passed++;
        @(negedge clock);
        #1;
        checks++;
        if (tx !== 1'b0) $display("FAIL start_latency: tx %b expected 0 one edge after push", tx);
        else passed++;
        repeat (39) @(negedge clock);
        checks++;
        if (tx !== 1'b1 || bus.read_value !== 32'h6)
            $display("FAIL stop_status: tx %b status %08h expected 1 / 00000006", tx, bus.read_value);
        else passed++;
        @(negedge clock);
        checks++;
        if (bus.read_value !== 32'h2) $display("FAIL idle_status: got %08h expected 00000002", bus.read_value);
        else passed++;
        wait_drain();
    endtask

    task automatic test_back_to_back();
        b2b_cnt = 0;
        for (int i = 0; i < 5; i++) sb.push_back(8'h41 + 8'(i));
        for (int i = 0; i < 6; i++) bus_drive(1'b1, BASE, 32'h41 + i);
        bus_drive(1'b0, STATUS_ADDR, 32'd0);
        #1;
        checks++;
        if (bus.read_value !== 32'h0000_040D) $display("FAIL full_status: got %08h expected 0000040d", bus.read_value);
        else passed++;
        wait_drain();
        checks++;
        if (b2b_cnt !== 4) $display("FAIL back_to_back: %0d gapless frames, expected 4", b2b_cnt);
        else passed++;
        checks++;
        if (bus.read_value !== 32'h0000_000A) $display("FAIL drained_status: got %08h expected 0000000a", bus.read_value);
        else passed++;
    endtask

    task automatic test_overflow_clear();
        bus_drive(1'b1, STATUS_ADDR, 32'h0000_0008);
        bus_drive(1'b0, STATUS_ADDR, 32'd0);
        #1;
        checks++;
        if (bus.read_value !== 32'h2) $display("FAIL ovf_clear: got %08h expected 00000002", bus.read_value);
        else passed++;
    endtask

    task automatic test_wide_and_unmapped();
        bus_drive(1'b1, BASE + 32'd8, 32'h0000_0055);
        #1;
        checks++;
        if (bus.select !== 1'b0 || bus.read_value !== 32'h0)
            $display("FAIL unmapped_decode: select %b read %08h expected 0 / 00000000", bus.select, bus.read_value);
        else passed++;
        bus_drive(1'b0, STATUS_ADDR, 32'd0);
        #1;
        checks++;
        if (bus.read_value !== 32'h2 || tx !== 1'b1)
            $display("FAIL unmapped_write: status %08h tx %b expected 00000002 / 1", bus.read_value, tx);
        else passed++;
        sb.push_back(8'h78);
        bus_drive(1'b1, BASE, 32'h1234_5678);
        bus_drive(1'b0, STATUS_ADDR, 32'd0);
        wait_drain();
    endtask

    task automatic test_reset_midframe();
        int bad = 0;
        mon_en = 1'b0;
        bus_drive(1'b1, BASE, 32'h11);
        bus_drive(1'b1, BASE, 32'h22);
        bus_drive(1'b1, BASE, 32'h33);
        bus_drive(1'b0, STATUS_ADDR, 32'd0);
        repeat (8) @(negedge clock);
        checks++;
        if (tx !== 1'b0 || bus.read_value !== 32'h0000_0204)
            $display("FAIL midframe_setup: tx %b status %08h expected 0 / 00000204", tx, bus.read_value);
        else passed++;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || bus.read_value !== 32'h2)
            $display("FAIL async_reset: tx %b status %08h expected 1 / 00000002 before next edge", tx, bus.read_value);
        else passed++;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clock);
            if (tx !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || bus.read_value !== 32'h2)
            $display("FAIL after_reset_idle: %0d low cycles, status %08h expected 0 / 00000002", bad, bus.read_value);
        else passed++;
        mon_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_comb_read();
        test_single_frame();
        test_back_to_back();
        test_overflow_clear();
        test_wide_and_unmapped();
        test_reset_midframe();
        checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_left: %0d bytes never transmitted, expected 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
